dkong_col_pal_gen: RTL and testbench

//  Parametrised colour palette stage: selects sprite vs. tile pixel, looks up a downloadable
//  RGB palette and drives registered, blanked RGB to the video DAC. Generalises the fixed
//  2x256x8 palette to N banks, any index/channel width and per-channel RAMs. Adds vblank-

---
 rtl/dkong_col_pal_gen.sv | 137 +++++++++++++
 tb/tb_dkong_col_pal_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dkong_col_pal_gen.sv
// ---------------------------------------------------------------------------
// dkong_col_pal_gen
//   Colour palette stage between the pixel mixer and the video DAC.
//   Picks the sprite pixel over the tile pixel unless the sprite is
//   transparent, looks the result up in a downloadable R/G/B palette with
//   one RAM per channel, and drives registered, blanked and optionally
//   inverted colour.  The palette bank is shadowed and only switches on a
//   vertical-blank rising edge.
//
// Ports
//   CLK_24M          system clock
//   W_1EF_RST        asynchronous reset, active-low
//   CLK_6M_EN        pixel-rate enable, one CLK_24M cycle wide
//   I_VRAM_D         tile pixel index
//   I_OBJ_D          sprite pixel index ([1:0]==0 is transparent)
//   I_CMPBLKn        composite blank, active-low
//   I_VBLANK         vertical blank, active-high
//   I_BANK           requested palette bank
//   I_INV            1 = invert colour outputs
//   O_R/O_G/O_B      colour outputs
//   O_BANK           palette bank currently in use
//   DL_ADDR/DL_WR/DL_DATA  palette download port
// ---------------------------------------------------------------------------
module dkong_col_pal_gen #(
  parameter int          IDX_W   = 6,
  parameter int          BANK_W  = 2,
  parameter int          CH_W    = 4,
  parameter logic [5:0]  DL_BASE = 6'b111100
) (
  input  logic              CLK_24M,
  input  logic              W_1EF_RST,
  input  logic              CLK_6M_EN,
  input  logic [IDX_W-1:0]  I_VRAM_D,
  input  logic [IDX_W-1:0]  I_OBJ_D,
  input  logic              I_CMPBLKn,
  input  logic              I_VBLANK,
  input  logic [BANK_W-1:0] I_BANK,
  input  logic              I_INV,
  output logic [CH_W-1:0]   O_R,
  output logic [CH_W-1:0]   O_G,
  output logic [CH_W-1:0]   O_B,
  output logic [BANK_W-1:0] O_BANK,
  input  logic [15:0]       DL_ADDR,
  input  logic              DL_WR,
  input  logic [7:0]        DL_DATA
);

  localparam int AW    = BANK_W + IDX_W;
  localparam int DEPTH = 1 << AW;

  logic [IDX_W-1:0]  pix;
  logic [BANK_W-1:0] bank_nx;
  logic              vb_d;
  logic [AW-1:0]     addr;
  logic              vis1;

  logic [CH_W-1:0]   ram_r [DEPTH];
  logic [CH_W-1:0]   ram_g [DEPTH];
  logic [CH_W-1:0]   ram_b [DEPTH];
  logic [CH_W-1:0]   rd_r, rd_g, rd_b;

  logic              dl_hit;
  logic              we_r, we_g, we_b;
  logic [AW-1:0]     dl_entry;
  logic [CH_W-1:0]   dl_val;
  logic              unused_dl;

  // Sprite wins unless its two low bits are zero (transparent).
  always_comb begin
    pix = I_VRAM_D;
    if (I_OBJ_D[1:0] != 2'b00) pix = I_OBJ_D;
  end

  // A bank latched on the vblank rising edge already applies to the pixel
  // sampled on that same enable, so S1 uses the next-state bank.
  always_comb begin
    bank_nx = O_BANK;
    if (I_VBLANK && !vb_d) bank_nx = I_BANK;
  end

  // S1. Visibility is stored active-high so the reset value blanks the
  // output until a real unblanked pixel has passed through the pipe.
  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      vb_d   <= 1'b0;
      O_BANK <= '0;
      addr   <= '0;
      vis1   <= 1'b0;
    end else if (CLK_6M_EN) begin
      vb_d   <= I_VBLANK;
      O_BANK <= bank_nx;
      addr   <= {bank_nx, pix};
      vis1   <= I_CMPBLKn;
    end
  end

  // Download decode; channel select 3 is ignored.
  always_comb begin
    dl_hit   = DL_WR && (DL_ADDR[15:10] == DL_BASE);
    we_r     = dl_hit && (DL_ADDR[9:8] == 2'd0);
    we_g     = dl_hit && (DL_ADDR[9:8] == 2'd1);
    we_b     = dl_hit && (DL_ADDR[9:8] == 2'd2);
    dl_entry = DL_ADDR[AW-1:0];
    dl_val   = DL_DATA[CH_W-1:0];
  end

  assign unused_dl = &{1'b0, DL_ADDR, DL_DATA};

  // Palette RAMs. The read sits in the same non-blocking block as the
  // write, so a same-entry write in the same cycle returns the old data.
  always_ff @(posedge CLK_24M) begin
    if (we_r) ram_r[dl_entry] <= dl_val;
    if (we_g) ram_g[dl_entry] <= dl_val;
    if (we_b) ram_b[dl_entry] <= dl_val;
    rd_r <= ram_r[addr];
    rd_g <= ram_g[addr];
    rd_b <= ram_b[addr];
  end

  // S2. Blanking overrides inversion so blank is 0 in both polarities.
  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      O_R <= '0;
      O_G <= '0;
      O_B <= '0;
    end else if (CLK_6M_EN) begin
      if (!vis1) begin
        O_R <= '0;
        O_G <= '0;
        O_B <= '0;
      end else begin
        {O_R, O_G, O_B} <= {(3*CH_W){I_INV}} ^ {rd_r, rd_g, rd_b};
      end
    end
  end

endmodule

// File: tb/tb_dkong_col_pal_gen.sv
module tb_dkong_col_pal_gen;

  logic        CLK_24M = 1'b0;
  logic        W_1EF_RST = 1'b0;
  logic        CLK_6M_EN = 1'b0;
  logic [5:0]  I_VRAM_D = '0;
  logic [5:0]  I_OBJ_D = '0;
  logic        I_CMPBLKn = 1'b0;
  logic        I_VBLANK = 1'b0;
  logic [1:0]  I_BANK = '0;
  logic        I_INV = 1'b0;
  logic [3:0]  O_R, O_G, O_B;
  logic [1:0]  O_BANK;
  logic [15:0] DL_ADDR = '0;
  logic        DL_WR = 1'b0;
  logic [7:0]  DL_DATA = '0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: palette contents, the bank in use, the vblank history
  // and the pixel waiting in the first stage.
  logic [3:0] pal [3][256];
  logic [1:0] m_bank  = '0;
  logic       m_vbd   = 1'b0;
  logic [7:0] m_entry = '0;
  logic       m_blank = 1'b1;

  dkong_col_pal_gen #(.IDX_W(6), .BANK_W(2), .CH_W(4), .DL_BASE(6'b111100)) dut (
    .CLK_24M(CLK_24M), .W_1EF_RST(W_1EF_RST), .CLK_6M_EN(CLK_6M_EN),
    .I_VRAM_D(I_VRAM_D), .I_OBJ_D(I_OBJ_D), .I_CMPBLKn(I_CMPBLKn),
    .I_VBLANK(I_VBLANK), .I_BANK(I_BANK), .I_INV(I_INV),
    .O_R(O_R), .O_G(O_G), .O_B(O_B), .O_BANK(O_BANK),
    .DL_ADDR(DL_ADDR), .DL_WR(DL_WR), .DL_DATA(DL_DATA)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (a[15:10] == 6'b111100 && a[9:8] != 2'd3) pal[a[9:8]][a[7:0]] = d[3:0];
  endfunction

  task automatic model_reset();
    m_bank = '0; m_vbd = 1'b0; m_entry = '0; m_blank = 1'b1;
  endtask

  // One download byte with the pixel enable held low.
  task automatic dl(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK_24M);
    DL_ADDR = a; DL_DATA = d; DL_WR = 1'b1;
    model_write(a, d);
    @(negedge CLK_24M);
    DL_WR = 1'b0;
  endtask

  // One pixel period of four CLK_24M cycles, enable in the last one.
  // Optional download byte in cycle wcyc (-1 = none). The colour shown at
  // the enable edge is the palette entry as it stood before the write
  // edge that ends cycle 2 (the last read ahead of the enable).
  task automatic pix(input logic [5:0] vram, input logic [5:0] obj, input logic blkn,
                     input logic inv, input logic vbl, input logic [1:0] bank,
                     input int wcyc, input logic [15:0] wa, input logic [7:0] wd);
    logic [3:0] look [3];
    logic [3:0] er, eg, eb;
    logic [5:0] p;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK_24M);
      if (c == 0) begin
        I_VRAM_D = vram; I_OBJ_D = obj; I_CMPBLKn = blkn;
        I_INV = inv; I_VBLANK = vbl; I_BANK = bank;
      end
      CLK_6M_EN = (c == 3);
      if (c == 2) for (int ch = 0; ch < 3; ch++) look[ch] = pal[ch][m_entry];
      if (c == wcyc) begin
        DL_ADDR = wa; DL_DATA = wd; DL_WR = 1'b1;
        model_write(wa, wd);
      end else begin
        DL_WR = 1'b0;
      end
    end
    er = m_blank ? 4'h0 : (look[0] ^ {4{inv}});
    eg = m_blank ? 4'h0 : (look[1] ^ {4{inv}});
    eb = m_blank ? 4'h0 : (look[2] ^ {4{inv}});
    p = (obj[1:0] == 2'b00) ? vram : obj;
    if (vbl && !m_vbd) m_bank = bank;
    m_vbd   = vbl;
    m_entry = {m_bank, p};
    m_blank = !blkn;
    @(posedge CLK_24M);
    #1;
    CLK_6M_EN = 1'b0;
    DL_WR = 1'b0;
    chk("R", O_R, er);
    chk("G", O_G, eg);
    chk("B", O_B, eb);
    chk("BANK", {2'b00, O_BANK}, {2'b00, m_bank});
  endtask

  initial begin
    logic [15:0] ra;
    int wc;

    // Reset state
    #22;
    chk("rst_R", O_R, 4'h0);
    chk("rst_G", O_G, 4'h0);
    chk("rst_B", O_B, 4'h0);
    chk("rst_BANK", {2'b00, O_BANK}, 4'h0);
    @(negedge CLK_24M);
    W_1EF_RST = 1'b1;

    // Fill every palette entry so the model knows the whole RAM.
    for (int ch = 0; ch < 3; ch++)
      for (int e = 0; e < 256; e++) begin
        ra = {6'b111100, 2'(ch), 8'(e)};
        dl(ra, 8'($urandom));
      end
    dl(16'hF005, 8'h5A);
    dl(16'hF105, 8'h03);
    dl(16'hF205, 8'hEC);
    dl(16'hF085, 8'h07);
    dl(16'hF185, 8'h09);
    dl(16'hF285, 8'h0E);

    // Blanked lead-in
    repeat (3) pix(6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, -1, '0, '0);

    // Basic lookup and inversion
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t2_R", O_R, 4'hA);
    chk("t2_G", O_G, 4'h3);
    chk("t2_B", O_B, 4'hC);
    pix(6'd5, 6'd0, 1'b1, 1'b1, 1'b0, 2'd0, -1, '0, '0);
    chk("t2_Rinv", O_R, 4'h5);
    chk("t2_Ginv", O_G, 4'hC);
    chk("t2_Binv", O_B, 4'h3);

    // Sprite priority and transparency
    pix(6'd5, 6'h06, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'h04, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'h04, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t3_transp_R", O_R, 4'hA);

    // Bank request held off until vblank rises
    repeat (3) pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd2, -1, '0, '0);
    chk("t4_hold", {2'b00, O_BANK}, 4'h0);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 2'd2, -1, '0, '0);
    chk("t4_switch", {2'b00, O_BANK}, 4'h2);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b1, 2'd1, -1, '0, '0);
    chk("t4_e85_R", O_R, 4'h7);
    chk("t4_e85_G", O_G, 4'h9);
    chk("t4_e85_B", O_B, 4'hE);
    chk("t4_level", {2'b00, O_BANK}, 4'h2);

    // Blanking in both polarities
    pix(6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'd0, 1'b0, 1'b1, 1'b0, 2'd0, -1, '0, '0);
    chk("t5_blank_inv", O_G, 4'h0);
    pix(6'd5, 6'd0, 1'b0, 1'b0, 1'b1, 2'd0, -1, '0, '0);
    chk("t5_blank", O_B, 4'h0);

    // Back on bank 0; write/read collision on entry 5
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2, 16'hF005, 8'h01);
    chk("t6_old", O_R, 4'hA);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t6_new", O_R, 4'h1);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 16'hF305, 8'h0F);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 16'hE005, 8'h0F);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 16'hF409, 8'h0F);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t6_ignored_R", O_R, 4'h1);
    chk("t6_ignored_G", O_G, 4'h3);

    // Reset mid-line: outputs drop without a clock edge
    @(negedge CLK_24M);
    #2;
    W_1EF_RST = 1'b0;
    #1;
    chk("t1_async_R", O_R, 4'h0);
    chk("t1_async_G", O_G, 4'h0);
    chk("t1_async_B", O_B, 4'h0);
    chk("t1_async_BANK", {2'b00, O_BANK}, 4'h0);
    model_reset();
    @(negedge CLK_24M);
    W_1EF_RST = 1'b1;
    pix(6'd5, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t1_still0", O_R, 4'h0);
    pix(6'd5, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, -1, '0, '0);
    chk("t1_first", O_R, 4'h1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      ra = {(($urandom % 4) == 0) ? 6'($urandom) : 6'b111100, 2'($urandom), 8'($urandom)};
      wc = (($urandom % 3) == 0) ? int'($urandom % 4) : -1;
      pix(6'($urandom), 6'($urandom), ($urandom % 5) != 0, 1'($urandom),
          ($urandom % 8) == 0, 2'($urandom), wc, ra, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
